// File: rtl/eth_tx_pixel_packer_if.sv
// Pixel-in / word-out bus bundle for the Ethernet TX pixel packer.
// master = packer side, slave = pixel source plus UDP TX sink side.
interface eth_tx_pixel_packer_if;
  logic [23:0] pix_data;
  logic        pix_sof;
  logic        pix_valid;
  logic        pix_ready;
  logic [31:0] tx_word;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_sop;
  logic        tx_eop;
  logic [15:0] tx_len;

  modport master (
    input  pix_data, pix_sof, pix_valid, tx_ready,
    output pix_ready, tx_word, tx_valid, tx_sop, tx_eop, tx_len
  );

  modport slave (
    output pix_data, pix_sof, pix_valid, tx_ready,
    input  pix_ready, tx_word, tx_valid, tx_sop, tx_eop, tx_len
  );
endinterface

// File: rtl/eth_tx_pixel_packer.sv
// Frames a 24-bit RGB pixel stream into 32-bit marker/pixel word packets for the UDP TX engine.
// Each line is cut into SEG_PIX-pixel segments with a forced idle gap between packets.
module eth_tx_pixel_packer #(
  parameter int unsigned H_PIX   = 1280,
  parameter int unsigned V_LINES = 960,
  parameter int unsigned SEG_PIX = 320,
  parameter int unsigned GAP_CYC = 16
) (
  input  logic                          sys_clk,
  input  logic                          rst_n,
  input  logic                          tx_en,
  eth_tx_pixel_packer_if.master         bus,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          err_sync
);

  localparam int unsigned NSEG = H_PIX / SEG_PIX;
  localparam int unsigned GW   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [31:0] FHEAD_W = 32'h4F7A2A33;
  localparam logic [31:0] LHEAD_W = 32'h3B6F3749;
  localparam logic [31:0] FTAIL_W = 32'h79215E69;

  localparam logic [15:0] LEN_FRAME = 16'(SEG_PIX + 3);
  localparam logic [15:0] LEN_LINE  = 16'(SEG_PIX + 2);
  localparam logic [15:0] LEN_SEG   = 16'(SEG_PIX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_SOF, S_FHEAD, S_LHEAD, S_SHEAD, S_PIX, S_GAP, S_FTAIL, S_TAIL_ACK
  } state_t;

  state_t          st;
  logic [10:0]     x_cnt;
  logic [10:0]     y_cnt;
  logic [6:0]      seg_idx;
  logic [GW-1:0]   gap_cnt;

  logic            ld;
  logic            last_x, last_seg, last_line, first_px, gap_done, go_next;
  logic            emit;
  logic [31:0]     w_word;
  logic            w_sop, w_eop;
  logic [15:0]     w_len;

  // Output register may only be reloaded once the current word is gone.
  assign ld        = !bus.tx_valid || bus.tx_ready;
  assign last_x    = (x_cnt == 11'(SEG_PIX - 1));
  assign last_seg  = (seg_idx == 7'(NSEG - 1));
  assign last_line = (y_cnt == 11'(V_LINES - 1));
  assign first_px  = (x_cnt == 11'd0) && (seg_idx == 7'd0) && (y_cnt == 11'd0);
  assign gap_done  = (gap_cnt == GW'(GAP_CYC - 1));

  // The sof pixel is held in WAIT_SOF so it becomes the first data word of the frame.
  assign bus.pix_ready = ((st == S_WAIT_SOF) && !(bus.pix_valid && bus.pix_sof)) ||
                         ((st == S_PIX) && ld);

  assign go_next = ((st == S_PIX) && ld && bus.pix_valid && last_x && (GAP_CYC == 0)) ||
                   ((st == S_GAP) && gap_done);

  // Word to load for the current state.
  always_comb begin
    emit   = 1'b0;
    w_word = '0;
    w_sop  = 1'b0;
    w_eop  = 1'b0;
    w_len  = '0;
    case (st)
      S_FHEAD: begin
        emit   = 1'b1;
        w_word = FHEAD_W;
        w_sop  = 1'b1;
        w_len  = LEN_FRAME;
      end
      S_LHEAD: begin
        emit   = 1'b1;
        w_word = LHEAD_W;
        w_sop  = (y_cnt != 11'd0);
        w_len  = (y_cnt != 11'd0) ? LEN_LINE : 16'd0;
      end
      S_SHEAD: begin
        emit   = 1'b1;
        w_word = {24'h555555, 1'b1, seg_idx};
        w_sop  = (seg_idx != 7'd0);
        w_len  = (seg_idx != 7'd0) ? LEN_SEG : 16'd0;
      end
      S_PIX: begin
        emit   = bus.pix_valid;
        w_word = {bus.pix_data[7:0], bus.pix_data[15:8], bus.pix_data[23:16], 8'h00};
        w_eop  = last_x;
      end
      S_FTAIL: begin
        emit   = 1'b1;
        w_word = FTAIL_W;
        w_sop  = 1'b1;
        w_eop  = 1'b1;
        w_len  = 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= S_IDLE;
      x_cnt        <= '0;
      y_cnt        <= '0;
      seg_idx      <= '0;
      gap_cnt      <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      err_sync     <= 1'b0;
      bus.tx_word  <= '0;
      bus.tx_valid <= 1'b0;
      bus.tx_sop   <= 1'b0;
      bus.tx_eop   <= 1'b0;
      bus.tx_len   <= '0;
    end else begin
      frame_done <= 1'b0;
      err_sync   <= 1'b0;

      if (ld) begin
        bus.tx_valid <= emit;
        bus.tx_sop   <= emit && w_sop;
        bus.tx_eop   <= emit && w_eop;
        bus.tx_len   <= emit ? w_len : 16'd0;
        if (emit) bus.tx_word <= w_word;
      end

      case (st)
        S_IDLE: begin
          if (tx_en) begin
            st   <= S_WAIT_SOF;
            busy <= 1'b1;
          end
        end
        S_WAIT_SOF: begin
          if (bus.pix_valid && bus.pix_sof) begin
            st      <= S_FHEAD;
            x_cnt   <= '0;
            y_cnt   <= '0;
            seg_idx <= '0;
          end
        end
        S_FHEAD: if (ld) st <= S_LHEAD;
        S_LHEAD: if (ld) st <= S_SHEAD;
        S_SHEAD: if (ld) st <= S_PIX;
        S_PIX: begin
          if (ld && bus.pix_valid) begin
            err_sync <= bus.pix_sof && !first_px;
            if (last_x) begin
              x_cnt   <= '0;
              gap_cnt <= '0;
              if (GAP_CYC != 0) st <= S_GAP;
            end else begin
              x_cnt <= x_cnt + 11'd1;
            end
          end
        end
        S_GAP: begin
          // Runs regardless of tx_ready so back-pressure does not stretch the gap.
          if (!gap_done) gap_cnt <= gap_cnt + GW'(1);
        end
        S_FTAIL: if (ld) st <= S_TAIL_ACK;
        S_TAIL_ACK: begin
          if (bus.tx_ready) begin
            frame_done <= 1'b1;
            busy       <= tx_en;
            st         <= tx_en ? S_WAIT_SOF : S_IDLE;
          end
        end
        default: st <= S_IDLE;
      endcase

      if (go_next) begin
        if (!last_seg) begin
          seg_idx <= seg_idx + 7'd1;
          st      <= S_SHEAD;
        end else if (!last_line) begin
          seg_idx <= '0;
          y_cnt   <= y_cnt + 11'd1;
          st      <= S_LHEAD;
        end else begin
          st <= S_FTAIL;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_pixel_packer.sv
// Randomized bench for eth_tx_pixel_packer: frames of pixels are turned into an expected
// word/packet list by a packet-level model and compared with every accepted output word.
module tb_eth_tx_pixel_packer;

  localparam int unsigned H    = 8;
  localparam int unsigned SP   = 4;
  localparam int unsigned V    = 2;
  localparam int unsigned G    = 2;
  localparam int unsigned NSEG = H / SP;

  localparam logic [31:0] FHEAD_W = 32'h4F7A2A33;
  localparam logic [31:0] LHEAD_W = 32'h3B6F3749;
  localparam logic [31:0] FTAIL_W = 32'h79215E69;

  typedef struct packed {
    logic [31:0] w;
    logic        sop;
    logic        eop;
    logic [15:0] len;
  } exp_t;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic tx_en   = 1'b0;
  logic busy, frame_done, err_sync;

  eth_tx_pixel_packer_if bus ();

  eth_tx_pixel_packer #(
    .H_PIX(H), .V_LINES(V), .SEG_PIX(SP), .GAP_CYC(G)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .tx_en      (tx_en),
    .bus        (bus.master),
    .busy       (busy),
    .frame_done (frame_done),
    .err_sync   (err_sync)
  );

  always #5 sys_clk = ~sys_clk;

  int          vectors     = 0;
  int          miscompares = 0;
  int          err_cnt     = 0;
  int          done_cnt    = 0;
  bit          mon_en      = 1'b0;
  bit          stall_prev  = 1'b0;
  logic [31:0] stall_w     = '0;
  exp_t        exp_q[$];
  logic [23:0] fpx[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pixword(input logic [23:0] p);
    return {p[7:0], p[15:8], p[23:16], 8'h00};
  endfunction

  function automatic exp_t ent(input logic [31:0] w);
    exp_t e;
    e   = '0;
    e.w = w;
    return e;
  endfunction

  // Packet-level reference: headers per frame/line/segment, then SP pixels, then the tail.
  task automatic model_frame();
    exp_t pkt[$];
    exp_t t;
    int   k;
    k = 0;
    for (int y = 0; y < int'(V); y++) begin
      for (int s = 0; s < int'(NSEG); s++) begin
        pkt.delete();
        if (y == 0 && s == 0) pkt.push_back(ent(FHEAD_W));
        if (s == 0) pkt.push_back(ent(LHEAD_W));
        pkt.push_back(ent({24'h555555, 1'b1, 7'(s)}));
        for (int i = 0; i < int'(SP); i++) begin
          pkt.push_back(ent(pixword(fpx[k])));
          k++;
        end
        pkt[0].sop = 1'b1;
        pkt[0].len = 16'(pkt.size());
        pkt[pkt.size()-1].eop = 1'b1;
        foreach (pkt[i]) exp_q.push_back(pkt[i]);
      end
    end
    t     = ent(FTAIL_W);
    t.sop = 1'b1;
    t.eop = 1'b1;
    t.len = 16'd1;
    exp_q.push_back(t);
  endtask

  // Output monitor: every accepted word against the model, plus hold-while-stalled.
  always @(negedge sys_clk) begin
    exp_t e;
    if (!mon_en || !rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("hold", {31'b0, bus.tx_valid, bus.tx_word}, {31'b0, 1'b1, stall_w});
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word_q_level", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("word", 64'(bus.tx_word), 64'(e.w));
          check("sop",  64'(bus.tx_sop),  64'(e.sop));
          check("eop",  64'(bus.tx_eop),  64'(e.eop));
          if (e.sop) check("len", 64'(bus.tx_len), 64'(e.len));
        end
      end
      stall_prev = bus.tx_valid && !bus.tx_ready;
      stall_w    = bus.tx_word;
      if (err_sync)   err_cnt++;
      if (frame_done) done_cnt++;
    end
  end

  task automatic run_frame(input string tag, input bit ramp, input int n_junk, input int err_idx,
                           input int rdy_pct, input int abort_at, input bit drop_en);
    logic [23:0] sd[$];
    bit          ss[$];
    int          idx, fpx_n, cyc;
    bit          hs, pend, fin;
    logic [31:0] pend_w;
    idx = 0; fpx_n = 0; cyc = 0; hs = 0; pend = 0; fin = 0; pend_w = '0;
    fpx.delete();
    for (int j = 0; j < int'(H * V); j++)
      fpx.push_back(ramp ? ((j == 0) ? 24'h123456 : 24'(j)) : 24'($urandom));
    model_frame();
    for (int j = 0; j < n_junk; j++) begin
      sd.push_back(24'($urandom));
      ss.push_back(1'b0);
    end
    for (int j = 0; j < int'(H * V); j++) begin
      sd.push_back(fpx[j]);
      ss.push_back((j == 0) || (j == err_idx));
    end
    err_cnt  = 0;
    done_cnt = 0;

    while (!fin && cyc < 3000) begin
      cyc++;
      bus.tx_ready = (int'($urandom_range(0, 99)) < rdy_pct);
      if (idx < sd.size() && $urandom_range(0, 3) != 0) begin
        bus.pix_valid = 1'b1;
        bus.pix_data  = sd[idx];
        bus.pix_sof   = ss[idx];
      end else begin
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.pix_sof   = 1'b0;
      end
      @(negedge sys_clk);
      if (pend) begin
        check({tag, "_latency"}, {31'b0, bus.tx_valid, bus.tx_word}, {31'b0, 1'b1, pend_w});
        pend = 1'b0;
      end
      hs  = bus.pix_valid && bus.pix_ready;
      fin = frame_done;
      @(posedge sys_clk);
      #1;
      if (hs) begin
        if (idx >= n_junk) begin
          pend   = 1'b1;
          pend_w = pixword(sd[idx]);
          fpx_n++;
        end
        idx++;
      end
      if (drop_en && fpx_n == 6) tx_en = 1'b0;
      if (abort_at > 0 && fpx_n == abort_at) begin
        check({tag, "_busy_before_reset"}, 64'(busy), 64'd1);
        mon_en        = 1'b0;
        rst_n         = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        #1;
        check({tag, "_valid_in_reset"}, 64'(bus.tx_valid), 64'd0);
        check({tag, "_busy_in_reset"},  64'(busy), 64'd0);
        exp_q.delete();
        repeat (3) @(posedge sys_clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        return;
      end
    end

    check({tag, "_frame_done_seen"}, 64'(fin), 64'd1);
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.tx_ready  = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check({tag, "_words_left"},  64'(exp_q.size()), 64'd0);
    check({tag, "_err_sync"},    64'(err_cnt), (err_idx > 0) ? 64'd1 : 64'd0);
    check({tag, "_frame_done"},  64'(done_cnt), 64'd1);
    check({tag, "_busy_after"},  64'(busy), 64'(tx_en));
    exp_q.delete();
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_data  = '0;
    bus.tx_ready  = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_tx_valid",   64'(bus.tx_valid),  64'd0);
    check("rst_busy",       64'(busy),          64'd0);
    check("rst_pix_ready",  64'(bus.pix_ready), 64'd0);
    check("rst_frame_done", 64'(frame_done),    64'd0);
    check("rst_err_sync",   64'(err_sync),      64'd0);
    check("rst_tx_sop",     64'(bus.tx_sop),    64'd0);
    check("rst_tx_len",     64'(bus.tx_len),    64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge sys_clk);
    #1;
    tx_en = 1'b1;

    run_frame("ramp",       1'b1, 0, -1, 100, 0, 1'b0);
    run_frame("junk3",      1'b0, 3, -1,  50, 0, 1'b0);
    run_frame("sof_mid",    1'b0, 0,  5,  60, 0, 1'b0);
    run_frame("en_drop",    1'b0, 1, -1,  70, 0, 1'b1);
    tx_en = 1'b1;
    run_frame("abort",      1'b0, 0, -1,  80, 6, 1'b0);
    run_frame("after_rst",  1'b0, 0, -1,  40, 0, 1'b0);
    run_frame("full_rate",  1'b0, 2, -1, 100, 0, 1'b0);
    run_frame("slow_sink",  1'b1, 0, -1,  25, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
